// File: rtl/adc_spi_responder.sv
// SPI slave standing in for the DE0-Nano 8-channel 12-bit ADC: oversampled pins,
// 3-bit channel address capture, 16-bit frames (4 zeros + sample, MSB first).
module adc_spi_responder #(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 12
) (
   input  logic                     clk,
   input  logic                     reset_b,
   input  logic                     sclk,
   input  logic                     cs_b,
   input  logic                     din,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic                     dout,
   output logic                     dout_oe,
   output logic                     frame_done,
   output logic                     frame_abort,
   output logic [2:0]               addr
);
   localparam int FRAME_W = 16;

   typedef enum logic {IDLE, ACTIVE} state_t;

   // [0],[1] synchronize, [2] is the delayed copy used for edge detection
   logic [2:0]         sclk_q, cs_q;
   logic [1:0]         din_q;
   state_t             state_q;
   logic [3:0]         bit_cnt_q;
   logic [FRAME_W-1:0] shreg_q;
   logic [2:0]         next_ch_q, addr_shift_q, addr_q;
   logic               armed_q, dout_q, dout_oe_q, frame_done_q, frame_abort_q;

   logic               sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic [DATA_W-1:0]  ch_sel;
   logic [FRAME_W-1:0] load_word;

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];

   always_comb begin
      ch_sel = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (3'(k) == next_ch_q) ch_sel = ch_data[k*DATA_W +: DATA_W];
   end

   assign load_word = {{(FRAME_W-DATA_W){1'b0}}, ch_sel};

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         sclk_q        <= 3'b111;
         cs_q          <= 3'b111;
         din_q         <= 2'b00;
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         shreg_q       <= '0;
         next_ch_q     <= '0;
         addr_shift_q  <= '0;
         addr_q        <= '0;
         armed_q       <= 1'b0;
         dout_q        <= 1'b0;
         dout_oe_q     <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
      end else begin
         sclk_q        <= {sclk_q[1:0], sclk};
         cs_q          <= {cs_q[1:0], cs_b};
         din_q         <= {din_q[0], din};
         dout_oe_q     <= ~cs_q[1];
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_q   <= ACTIVE;
                  shreg_q   <= load_word;
                  bit_cnt_q <= '0;
                  armed_q   <= 1'b1;
                  dout_q    <= load_word[FRAME_W-1];
               end
            end
            ACTIVE: begin
               // cs_b rising takes priority over any coincident sclk edge
               if (cs_rise) begin
                  state_q       <= IDLE;
                  frame_abort_q <= (bit_cnt_q != 4'd0);
                  bit_cnt_q     <= '0;
                  armed_q       <= 1'b0;
                  dout_q        <= 1'b0;
               end else if (sclk_rise) begin
                  if (bit_cnt_q >= 4'd2 && bit_cnt_q <= 4'd4)
                     addr_shift_q <= {addr_shift_q[1:0], din_q[1]};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd15) begin
                     frame_done_q <= 1'b1;
                     addr_q       <= addr_shift_q;
                     next_ch_q    <= addr_shift_q;
                  end
               end else if (sclk_fall) begin
                  if (bit_cnt_q == 4'd0) begin
                     // first fall after cs_b: MSB already out; otherwise back-to-back frame
                     if (armed_q) begin
                        armed_q <= 1'b0;
                     end else begin
                        shreg_q <= load_word;
                        dout_q  <= load_word[FRAME_W-1];
                     end
                  end else begin
                     shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                     dout_q  <= shreg_q[FRAME_W-2];
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dout        = dout_q & dout_oe_q;
   assign dout_oe     = dout_oe_q;
   assign frame_done  = frame_done_q;
   assign frame_abort = frame_abort_q;
   assign addr        = addr_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: an SPI master at clk/8 against a frame-level
// channel/address model, directed scenarios followed by randomized transfers.
module tb_adc_spi_responder;
   logic        clk = 1'b0;
   logic        reset_b, sclk, cs_b, din;
   logic [95:0] ch_data;
   logic        dout, dout_oe, frame_done, frame_abort;
   logic [2:0]  addr;

   logic [11:0] ch_model [8];
   int          model_next, model_addr;
   int          done_cnt, abort_cnt;
   int          errors, checks;

   always #5 clk = ~clk;

   always_comb begin
      ch_data = '0;
      for (int k = 0; k < 8; k++) ch_data[k*12 +: 12] = ch_model[k];
   end

   always @(negedge clk) begin
      if (frame_done)  done_cnt++;
      if (frame_abort) abort_cnt++;
   end

   adc_spi_responder #(.NUM_CH(8), .DATA_W(12)) dut (
      .clk(clk), .reset_b(reset_b), .sclk(sclk), .cs_b(cs_b), .din(din),
      .ch_data(ch_data), .dout(dout), .dout_oe(dout_oe),
      .frame_done(frame_done), .frame_abort(frame_abort), .addr(addr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // n clk rising edges, then settle 2ns into the cycle
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset_b = 1'b0;
      #1;
      chk("rst_dout", dout, 0);
      chk("rst_oe", dout_oe, 0);
      chk("rst_addr", addr, 0);
      cs_b = 1'b1; sclk = 1'b1; din = 1'b0;
      tick(3);
      reset_b = 1'b1;
      tick(2);
      model_next = 0;
      model_addr = 0;
   endtask

   // Master: nbits sclk cycles with cs_b low; frame f carries address addrs[f*3 +: 3].
   task automatic xfer(input int nbits, input logic [8:0] addrs, input bit raise_cs,
                       input bit scramble);
      logic [15:0] cap, exp;
      int d0, a0, f, j;
      logic [2:0] fa;
      d0 = done_cnt; a0 = abort_cnt;
      cap = '0; exp = '0;
      cs_b = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("oe_lat", dout_oe, 0);
      @(posedge clk); #1;
      chk("oe_on", dout_oe, 1);
      tick(1);
      for (int i = 0; i < nbits; i++) begin
         f = i / 16; j = i % 16;
         fa = addrs[f*3 +: 3];
         if (j == 0) exp = {4'h0, ch_model[model_next]};
         sclk = 1'b0;
         if (j >= 2 && j <= 4) din = fa[4-j];
         if (scramble && j == 8) ch_model[$urandom_range(0, 7)] = 12'($urandom);
         tick(4);
         cap = {cap[14:0], dout};
         sclk = 1'b1;
         tick(4);
         if (j == 15) begin
            chk("frame_word", cap, exp);
            model_next = fa;
            model_addr = fa;
            chk("addr_upd", addr, model_addr);
         end
      end
      if (raise_cs) begin
         cs_b = 1'b1;
         tick(5);
         chk("done_cnt", done_cnt - d0, nbits / 16);
         chk("abort_cnt", abort_cnt - a0, (nbits % 16 != 0) ? 1 : 0);
         chk("addr_end", addr, model_addr);
         chk("oe_off", dout_oe, 0);
         chk("dout_off", dout, 0);
      end
   endtask

   initial begin
      errors = 0; checks = 0; done_cnt = 0; abort_cnt = 0;
      reset_b = 1'b0; cs_b = 1'b1; sclk = 1'b1; din = 1'b0;
      for (int k = 0; k < 8; k++) ch_model[k] = 12'(k * 12'h111);
      model_next = 0; model_addr = 0;

      // reset held while cs_b toggles
      tick(2);
      for (int i = 0; i < 4; i++) begin
         cs_b = ~cs_b;
         tick(4);
         chk("rst_hold_oe", dout_oe, 0);
         chk("rst_hold_dout", dout, 0);
      end
      chk("rst_hold_addr", addr, 0);
      chk("rst_pulses", done_cnt + abort_cnt, 0);
      cs_b = 1'b1;
      tick(2);
      reset_b = 1'b1;
      tick(3);

      // single frame, then pipelined channel
      ch_model[0] = 12'hA5C;
      ch_model[5] = 12'h3F1;
      xfer(16, 9'd5, 1'b1, 1'b0);
      chk("single_addr", addr, 3'd5);
      xfer(16, 9'd2, 1'b1, 1'b0);
      chk("pipe_addr", addr, 3'd2);

      // continuous mode from a fresh reset: frames return ch0, ch1, ch4
      for (int k = 0; k < 8; k++) ch_model[k] = 12'(k * 12'h111);
      do_reset();
      xfer(48, {3'd7, 3'd4, 3'd1}, 1'b1, 1'b0);
      chk("cont_addr", addr, 3'd7);

      // abort after 9 sclk with address 6; next frame still serves ch7
      xfer(9, 9'd6, 1'b1, 1'b0);
      chk("abort_addr", addr, 3'd7);
      xfer(16, 9'd1, 1'b1, 1'b0);

      // reset mid-frame at bit 7, then a full frame addressing 3 serves ch0
      ch_model[0] = 12'h5A3;
      xfer(7, 9'd3, 1'b0, 1'b0);
      do_reset();
      xfer(16, 9'd3, 1'b1, 1'b0);
      chk("rstmid_addr", addr, 3'd3);

      // randomized transfers: fresh samples, addresses, lengths, mid-frame data changes
      for (int t = 0; t < 8; t++) begin
         for (int k = 0; k < 8; k++) ch_model[k] = 12'($urandom);
         xfer(int'($urandom_range(1, 48)), 9'($urandom), 1'b1, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
